// File: rtl/mc_main_control.sv
// mc_main_control
// Main control FSM of the multicycle processor. Sequences every instruction
// through fetch, decode, execute, memory and writeback, and drives the
// datapath enables, mux selects and the 4-bit ALUOp for the ALU control block.
//
// State table (code | state    | meaning)
//   0  | S_RST    | post-reset hold, all outputs idle
//   1  | S_FETCH  | read instruction at PC, PC += 4 (both gated by mem_ready)
//   2  | S_DECODE | decode opcode, branch target into ALUOut
//   3  | S_MEMADR | effective address A + imm for lw/sw
//   4  | S_MEMRD  | data read, waits on mem_ready
//   5  | S_MEMWB  | MDR written to rt
//   6  | S_MEMWR  | data write, waits on mem_ready
//   7  | S_RTEXEC | R-type ALU operation (funct)
//   8  | S_RTWB   | ALUOut written to rd
//   9  | S_ITEXEC | immediate ALU operation
//   10 | S_ITWB   | ALUOut written to rt
//   11 | S_BRANCH | compare A/B, conditional PC load from ALUOut
//   12 | S_JUMP   | PC loaded from jump target
//
// Ports
//   clk, rst_n      clock (rising edge), async active-low reset
//   opcode[5:0]     IR[31:26], valid from S_DECODE onward
//   mem_ready       memory completes current access this cycle
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0], ext_zero,
//   pc_src[1:0], alu_op[3:0]   datapath controls
//   illegal_op      one-cycle pulse in S_DECODE on an undefined opcode
//   state[3:0]      current state code for debug

module mc_main_control #(
  parameter int RESET_PC_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [1:0] pc_src,
  output logic [3:0] alu_op,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTEXEC = 4'd7,
    S_RTWB   = 4'd8,
    S_ITEXEC = 4'd9,
    S_ITWB   = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGT   = 6'b010000;
  localparam logic [5:0] OP_BGE   = 6'b010001;
  localparam logic [5:0] OP_BLT   = 6'b010010;
  localparam logic [5:0] OP_BLE   = 6'b010011;

  localparam logic [3:0] ALU_FUNCT = 4'd0;
  localparam logic [3:0] ALU_ADD   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_BEQ   = 4'd4;
  localparam logic [3:0] ALU_BNE   = 4'd5;
  localparam logic [3:0] ALU_BGT   = 4'd6;
  localparam logic [3:0] ALU_BGE   = 4'd7;
  localparam logic [3:0] ALU_BLT   = 4'd8;
  localparam logic [3:0] ALU_BLE   = 4'd9;

  localparam logic [3:0] HOLD_TC = 4'(RESET_PC_HOLD);

  state_t     state_q, state_d;
  logic [3:0] hold_cnt, hold_d;
  logic       is_logic_imm;

  // andi/ori take a zero-extended immediate; addi is sign-extended.
  assign is_logic_imm = (opcode == OP_ANDI) || (opcode == OP_ORI);
  assign state        = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RST;
      hold_cnt <= 4'd0;
    end else begin
      state_q  <= state_d;
      hold_cnt <= hold_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    hold_d        = 4'd0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ext_zero      = 1'b0;
    pc_src        = 2'b00;
    alu_op        = ALU_FUNCT;
    illegal_op    = 1'b0;

    case (state_q)
      S_RST: begin
        // hold_cnt starts at 0 on release, so the first fetch follows
        // RESET_PC_HOLD + 1 rising edges after rst_n deasserts.
        if (hold_cnt == HOLD_TC) state_d = S_FETCH;
        else                     hold_d  = hold_cnt + 4'd1;
      end

      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        // IR and PC load only on the cycle the instruction word arrives.
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_RTYPE:                    state_d = S_RTEXEC;
          OP_LW, OP_SW:                state_d = S_MEMADR;
          OP_ADDI, OP_ANDI, OP_ORI:    state_d = S_ITEXEC;
          OP_BEQ, OP_BNE, OP_BGT,
          OP_BGE, OP_BLT, OP_BLE:      state_d = S_BRANCH;
          OP_J:                        state_d = S_JUMP;
          default: begin
            // PC already advanced in fetch; just skip the word.
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end

      S_RTEXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = S_RTWB;
      end

      S_RTWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end

      S_ITEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_zero  = is_logic_imm;
        case (opcode)
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          default: alu_op = ALU_ADD;
        endcase
        state_d = S_ITWB;
      end

      S_ITWB: begin
        reg_write = 1'b1;
        ext_zero  = is_logic_imm;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        case (opcode)
          OP_BNE:  alu_op = ALU_BNE;
          OP_BGT:  alu_op = ALU_BGT;
          OP_BGE:  alu_op = ALU_BGE;
          OP_BLT:  alu_op = ALU_BLT;
          OP_BLE:  alu_op = ALU_BLE;
          default: alu_op = ALU_BEQ;
        endcase
        state_d = S_FETCH;
      end

      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        state_d  = S_FETCH;
      end

      // Codes 13..15: recover to fetch with every output idle.
      default: state_d = S_FETCH;
    endcase
  end

endmodule
